// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues single-beat AR/R reads and presents (pc, inst) to IF/ID.
// Optional access-fault reporting (ifu_rresp / fetch_fault) is enabled with `define IFU_ACCESS_FAULT_EN.
module ifu_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(32'h8000_0000),
    parameter logic [DATA_W-1:0] INST_NOP   = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ifu_arvalid,
    input  logic              ifu_arready,
    output logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_rvalid,
    output logic              ifu_rready,
    input  logic [DATA_W-1:0] ifu_rdata,
`ifdef IFU_ACCESS_FAULT_EN
    input  logic [1:0]        ifu_rresp,
    output logic              fetch_fault,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [DATA_W-1:0] fetch_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
    logic [ADDR_W-1:0] r_fpc, w_fpc_nxt;
    logic [DATA_W-1:0] r_finst, w_finst_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_arvalid, w_arvalid_nxt;
    logic              r_rready, w_rready_nxt;
    logic              r_fvalid, w_fvalid_nxt;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_ar_hs, w_r_hs, w_f_hs;
    logic              w_resp_err;

    assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
    assign w_ar_hs    = r_arvalid & ifu_arready;
    assign w_r_hs     = r_rready & ifu_rvalid;
    assign w_f_hs     = r_fvalid & fetch_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_ADDR;
            r_araddr  <= RESET_ADDR;
            r_drop    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_fvalid  <= 1'b0;
            r_fpc     <= RESET_ADDR;
            r_finst   <= INST_NOP;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_araddr  <= w_araddr_nxt;
            r_drop    <= w_drop_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_fvalid  <= w_fvalid_nxt;
            r_fpc     <= w_fpc_nxt;
            r_finst   <= w_finst_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = redirect_valid ? w_redir_pc : r_pc;
        w_araddr_nxt  = r_araddr;
        w_drop_nxt    = r_drop;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_fvalid_nxt  = r_fvalid;
        w_fpc_nxt     = r_fpc;
        w_finst_nxt   = r_finst;
        case (r_state)
            S_REQ: begin
                // arvalid is low here only right after reset: nothing is outstanding yet
                if (!r_arvalid) begin
                    w_arvalid_nxt = 1'b1;
                    w_araddr_nxt  = w_pc_nxt;
                end else begin
                    if (w_ar_hs) begin
                        w_arvalid_nxt = 1'b0;
                        w_rready_nxt  = 1'b1;
                        w_state_nxt   = S_RESP;
                    end
                    if (redirect_valid) begin
                        w_drop_nxt = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (w_r_hs) begin
                    w_rready_nxt = 1'b0;
                    if (r_drop || redirect_valid) begin
                        w_drop_nxt    = 1'b0;
                        w_state_nxt   = S_REQ;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = w_pc_nxt;
                    end else begin
                        w_fvalid_nxt = 1'b1;
                        w_fpc_nxt    = r_pc;
                        w_finst_nxt  = w_resp_err ? INST_NOP : ifu_rdata;
                        w_state_nxt  = S_OUT;
                    end
                end else if (redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            S_OUT: begin
                // A redirect on the handshake cycle still delivers, but the pc follows the redirect
                if (w_f_hs || redirect_valid) begin
                    if (!redirect_valid) begin
                        w_pc_nxt = r_pc + ADDR_W'(4);
                    end
                    w_fvalid_nxt  = 1'b0;
                    w_finst_nxt   = INST_NOP;
                    w_state_nxt   = S_REQ;
                    w_arvalid_nxt = 1'b1;
                    w_araddr_nxt  = w_pc_nxt;
                end
            end
            default: begin
                w_state_nxt   = S_REQ;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_fvalid_nxt  = 1'b0;
                w_finst_nxt   = INST_NOP;
                w_drop_nxt    = 1'b0;
            end
        endcase
    end

`ifdef IFU_ACCESS_FAULT_EN
    logic r_fault;
    logic w_fload, w_fclear;

    assign w_resp_err = |ifu_rresp;
    assign w_fload    = (r_state == S_RESP) & w_r_hs & ~r_drop & ~redirect_valid;
    assign w_fclear   = redirect_valid | w_f_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_fload) begin
            r_fault <= w_resp_err;
        end else if (w_fclear) begin
            r_fault <= 1'b0;
        end
    end

    assign fetch_fault = r_fault;
`else
    assign w_resp_err = 1'b0;
`endif

    assign ifu_arvalid = r_arvalid;
    assign ifu_araddr  = r_araddr;
    assign ifu_rready  = r_rready;
    assign fetch_valid = r_fvalid;
    assign fetch_pc    = r_fpc;
    assign fetch_inst  = r_finst;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: reset-release vector table, directed corner sequences,
// then random traffic against a memory model and a delivered-instruction-stream reference.
module tb_ifu_fetch;

    localparam logic [31:0] RST_A = 32'h8000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic        redirect_valid, fetch_valid, fetch_ready;
    logic [31:0] redirect_pc, fetch_pc, fetch_inst;
`ifdef IFU_ACCESS_FAULT_EN
    logic [1:0]  ifu_rresp = 2'b00;
    logic        fetch_fault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(
        .ADDR_W(32), .DATA_W(32), .RESET_ADDR(RST_A), .INST_NOP(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
`ifdef IFU_ACCESS_FAULT_EN
        .ifu_rresp(ifu_rresp), .fetch_fault(fetch_fault),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst)
    );

    // Instruction memory contents: any fixed scrambling of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_in(input logic ar, input logic rv, input logic [31:0] rd,
                          input logic fr, input logic rdv, input logic [31:0] rpc);
        ifu_arready    = ar;
        ifu_rvalid     = rv;
        ifu_rdata      = rd;
        fetch_ready    = fr;
        redirect_valid = rdv;
        redirect_pc    = rpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Three-cycle zero-wait fetch starting in REQ with arvalid already high.
    task automatic fetch_zero_wait(input logic [31:0] pc, input logic redir, input logic [31:0] rpc);
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("fzw.arvalid", ifu_arvalid, 1'b1);
        check("fzw.araddr", ifu_araddr, pc);
        next_cycle();
        set_in(1'b0, 1'b1, mem_word(pc), 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("fzw.rready", ifu_rready, 1'b1);
        check_b("fzw.fvalid_early", fetch_valid, 1'b0);
        next_cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, redir, rpc);
        @(negedge clk);
        check_b("fzw.fvalid", fetch_valid, 1'b1);
        check("fzw.fpc", fetch_pc, pc);
        check("fzw.finst", fetch_inst, mem_word(pc));
        next_cycle();
    endtask

    typedef struct {
        logic        ar, rv;
        logic [31:0] rd;
        logic        fr, rdv;
        logic [31:0] rpc;
        logic        e_arv;
        logic [31:0] e_araddr;
        logic        e_rr, e_fv;
        logic [31:0] e_fpc, e_finst;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [31:0] rd, input logic e_arv, input logic [31:0] e_araddr,
                        input logic e_rr, input logic e_fv, input logic [31:0] e_fpc,
                        input logic [31:0] e_finst);
        vec_t v;
        v.ar = 1'b1; v.rv = 1'b1; v.rd = rd; v.fr = 1'b1; v.rdv = 1'b0; v.rpc = 32'h0;
        v.e_arv = e_arv; v.e_araddr = e_araddr; v.e_rr = e_rr; v.e_fv = e_fv;
        v.e_fpc = e_fpc; v.e_finst = e_finst;
        vecs.push_back(v);
    endtask

    // Random-phase model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_delay;
    logic [31:0] exp_pc;
    int          delivered;
    logic        p_arv, p_arr, p_fv, p_fr, p_rdv;
    logic [31:0] p_araddr, p_fpc, p_finst;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time %0t exceeded limit %0d", $time, 3_000_000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Zero-wait memory, fetch_ready always high, from reset release.
        addv(mem_word(RST_A),       1'b0, RST_A,          1'b0, 1'b0, RST_A,          NOP);
        addv(mem_word(RST_A),       1'b1, RST_A,          1'b0, 1'b0, RST_A,          NOP);
        addv(mem_word(RST_A),       1'b0, RST_A,          1'b1, 1'b0, RST_A,          NOP);
        addv(mem_word(RST_A),       1'b0, RST_A,          1'b0, 1'b1, RST_A,          mem_word(RST_A));
        addv(mem_word(RST_A + 4),   1'b1, RST_A + 4,      1'b0, 1'b0, RST_A,          NOP);
        addv(mem_word(RST_A + 4),   1'b0, RST_A + 4,      1'b1, 1'b0, RST_A,          NOP);
        addv(mem_word(RST_A + 4),   1'b0, RST_A + 4,      1'b0, 1'b1, RST_A + 4,      mem_word(RST_A + 4));
        addv(mem_word(RST_A + 8),   1'b1, RST_A + 8,      1'b0, 1'b0, RST_A + 4,      NOP);
        addv(mem_word(RST_A + 8),   1'b0, RST_A + 8,      1'b1, 1'b0, RST_A + 4,      NOP);
        addv(mem_word(RST_A + 8),   1'b0, RST_A + 8,      1'b0, 1'b1, RST_A + 8,      mem_word(RST_A + 8));
        addv(mem_word(RST_A + 12),  1'b1, RST_A + 12,     1'b0, 1'b0, RST_A + 8,      NOP);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].ar, vecs[i].rv, vecs[i].rd, vecs[i].fr, vecs[i].rdv, vecs[i].rpc);
            @(negedge clk);
            check_b($sformatf("vec%0d.arvalid", i), ifu_arvalid, vecs[i].e_arv);
            check($sformatf("vec%0d.araddr", i), ifu_araddr, vecs[i].e_araddr);
            check_b($sformatf("vec%0d.rready", i), ifu_rready, vecs[i].e_rr);
            check_b($sformatf("vec%0d.fvalid", i), fetch_valid, vecs[i].e_fv);
            check($sformatf("vec%0d.fpc", i), fetch_pc, vecs[i].e_fpc);
            check($sformatf("vec%0d.finst", i), fetch_inst, vecs[i].e_finst);
            next_cycle();
        end

        // Backpressure: 5 cycles of fetch_ready=0 in OUT.
        do_reset();
        next_cycle();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        set_in(1'b0, 1'b1, mem_word(RST_A), 1'b0, 1'b0, 32'h0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check_b("bp.fvalid", fetch_valid, 1'b1);
            check("bp.fpc", fetch_pc, RST_A);
            check("bp.finst", fetch_inst, mem_word(RST_A));
            check_b("bp.no_ar", ifu_arvalid, 1'b0);
            next_cycle();
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_b("bp.release_fvalid", fetch_valid, 1'b1);
        next_cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("bp.next_arvalid", ifu_arvalid, 1'b1);
        check("bp.next_araddr", ifu_araddr, RST_A + 4);
        next_cycle();

        // arready held low for 4 cycles, redirect to 0x80000103 in the second.
        do_reset();
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b0, (i == 2), 32'h8000_0103);
            @(negedge clk);
            check_b("arhold.arvalid", ifu_arvalid, 1'b1);
            check("arhold.araddr", ifu_araddr, RST_A);
            check_b("arhold.fvalid", fetch_valid, 1'b0);
            next_cycle();
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("arhold.accept_addr", ifu_araddr, RST_A);
        next_cycle();
        set_in(1'b0, 1'b1, mem_word(RST_A), 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("arhold.rready", ifu_rready, 1'b1);
        check_b("arhold.fvalid_resp", fetch_valid, 1'b0);
        next_cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("arhold.dropped", fetch_valid, 1'b0);
        check_b("arhold.re_arvalid", ifu_arvalid, 1'b1);
        check("arhold.re_araddr", ifu_araddr, 32'h8000_0100);
        next_cycle();
        fetch_zero_wait(32'h8000_0100, 1'b0, 32'h0);

        // Redirect on the same cycle as the fetch handshake at 0x80000010.
        do_reset();
        next_cycle();
        for (int i = 0; i < 4; i++) fetch_zero_wait(RST_A + 32'(4 * i), 1'b0, 32'h0);
        fetch_zero_wait(RST_A + 32'h10, 1'b1, 32'h8000_0200);
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_b("rdhs.fvalid_once", fetch_valid, 1'b0);
        check_b("rdhs.arvalid", ifu_arvalid, 1'b1);
        check("rdhs.araddr", ifu_araddr, 32'h8000_0200);
        next_cycle();
        fetch_zero_wait(32'h8000_0200, 1'b0, 32'h0);

        // Reset pulse while in RESP; stale response offered after release.
        do_reset();
        next_cycle();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("rstresp.in_resp", ifu_rready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_b("rstresp.arvalid", ifu_arvalid, 1'b0);
        check_b("rstresp.rready", ifu_rready, 1'b0);
        check_b("rstresp.fvalid", fetch_valid, 1'b0);
        check("rstresp.araddr", ifu_araddr, RST_A);
        check("rstresp.fpc", fetch_pc, RST_A);
        check("rstresp.finst", fetch_inst, NOP);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_b("rstresp.rel_rready", ifu_rready, 1'b0);
        next_cycle();
        set_in(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("rstresp.stale_rready", ifu_rready, 1'b0);
        check_b("rstresp.restart_arvalid", ifu_arvalid, 1'b1);
        check("rstresp.restart_araddr", ifu_araddr, RST_A);
        next_cycle();
        fetch_zero_wait(RST_A, 1'b0, 32'h0);

`ifdef IFU_ACCESS_FAULT_EN
        // Error response on the first fetch.
        do_reset();
        check_b("fault.reset", fetch_fault, 1'b0);
        next_cycle();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        next_cycle();
        set_in(1'b0, 1'b1, mem_word(RST_A), 1'b0, 1'b0, 32'h0);
        ifu_rresp = 2'b10;
        next_cycle();
        ifu_rresp = 2'b00;
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_b("fault.fvalid", fetch_valid, 1'b1);
        check("fault.finst", fetch_inst, NOP);
        check_b("fault.flag", fetch_fault, 1'b1);
        next_cycle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_b("fault.cleared", fetch_fault, 1'b0);
        check_b("fault.fvalid_after", fetch_valid, 1'b0);
        next_cycle();
`endif

        // Random traffic: memory model with variable latency, random backpressure and redirects.
        do_reset();
        mem_busy = 1'b0; mem_addr = 32'h0; mem_delay = 0;
        exp_pc = RST_A; delivered = 0;
        p_arv = 1'b0; p_arr = 1'b0; p_fv = 1'b0; p_fr = 1'b0; p_rdv = 1'b0;
        p_araddr = 32'h0; p_fpc = 32'h0; p_finst = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ifu_arready    = 1'($urandom_range(0, 1));
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            if (mem_busy && mem_delay == 0) begin
                ifu_rvalid = 1'b1;
                ifu_rdata  = mem_word(mem_addr);
            end else begin
                ifu_rvalid = 1'b0;
                ifu_rdata  = $urandom;
            end
            @(negedge clk);
            if (p_arv && !p_arr) begin
                check_b("rnd.ar_hold_valid", ifu_arvalid, 1'b1);
                check("rnd.ar_hold_addr", ifu_araddr, p_araddr);
            end
            if (p_fv && !p_fr && !p_rdv) begin
                check_b("rnd.f_hold_valid", fetch_valid, 1'b1);
                check("rnd.f_hold_pc", fetch_pc, p_fpc);
                check("rnd.f_hold_inst", fetch_inst, p_finst);
            end
            if (!fetch_valid) check("rnd.idle_inst", fetch_inst, NOP);
            if (ifu_rvalid && ifu_rready) mem_busy = 1'b0;
            else if (mem_busy && mem_delay > 0) mem_delay--;
            if (ifu_arvalid && ifu_arready) begin
                check_b("rnd.one_outstanding", mem_busy, 1'b0);
                check("rnd.ar_align", {30'd0, ifu_araddr[1:0]}, 32'd0);
                mem_busy  = 1'b1;
                mem_addr  = ifu_araddr;
                mem_delay = $urandom_range(0, 3);
            end
            if (fetch_valid && fetch_ready) begin
                check("rnd.deliver_pc", fetch_pc, exp_pc);
                check("rnd.deliver_inst", fetch_inst, mem_word(exp_pc));
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            p_arv = ifu_arvalid; p_arr = ifu_arready; p_araddr = ifu_araddr;
            p_fv = fetch_valid; p_fr = fetch_ready; p_rdv = redirect_valid;
            p_fpc = fetch_pc; p_finst = fetch_inst;
            next_cycle();
        end
        checks++;
        if (delivered < 50) begin
            errors++;
            $display("FAIL rnd.progress: delivered %0d instructions, need at least %0d", delivered, 50);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit on the producer side of the IF->ID valid/ready interface.
- Owns the PC and issues single-beat AXI-lite-style reads (AR/R channels) to instruction memory.
- Presents each fetched (pc, inst) pair to the IF/ID pipe register with a registered valid that is held until ready.
- Accepts a one-cycle redirect (branch/jump/trap target) that can arrive in any state.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- RESET_ADDR, 32'h8000_0000, first PC fetched after reset.
- INST_NOP, 32'h0000_0013, value driven on fetch_inst when no instruction is held.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- ifu_arvalid  output  1  read address valid.
- ifu_arready  input  1  read address ready.
- ifu_araddr  output  ADDR_W  read address; equals the current PC.
- ifu_rvalid  input  1  read data valid.
- ifu_rready  output  1  read data ready.
- ifu_rdata  input  DATA_W  read data.
- redirect_valid  input  1  one-cycle pulse: discard current work and fetch from redirect_pc.
- redirect_pc  input  ADDR_W  redirect target; bits [1:0] are forced to 0 internally.
- fetch_valid  output  1  (fetch_pc, fetch_inst) valid toward the IF/ID pipe.
- fetch_ready  input  1  IF/ID pipe can accept.
- fetch_pc  output  ADDR_W  PC of the presented instruction.
- fetch_inst  output  DATA_W  presented instruction.

Behaviour:
- Reset (async assert, sync deassert):
  - pc=RESET_ADDR, state=REQ, drop=0.
  - ifu_arvalid=0, ifu_rready=0.
  - fetch_valid=0, fetch_pc=RESET_ADDR, fetch_inst=INST_NOP.
- All outputs are registered. ifu_arvalid rises on the first clock edge after rst deasserts.
- REQ state:
  - Drive ifu_arvalid=1 and ifu_araddr=pc.
  - arvalid and araddr must stay stable until ifu_arready=1; no retraction, even on redirect.
  - On handshake: ifu_arvalid->0, ifu_rready->1, go to RESP.
- RESP state:
  - ifu_rready=1.
  - On ifu_rvalid with drop=0: latch fetch_pc=pc and fetch_inst=ifu_rdata, set fetch_valid=1, ifu_rready->0, go to OUT.
  - On ifu_rvalid with drop=1: discard data, clear drop, go to REQ (new pc).
- OUT state:
  - fetch_valid, fetch_pc and fetch_inst are held stable until fetch_ready=1.
  - On handshake: fetch_valid->0, fetch_inst->INST_NOP, pc<=pc+4 (wraps modulo 2^ADDR_W), go to REQ.
- Redirect (checked every cycle, highest priority for the pc update):
  - pc<=redirect_pc & ~3.
  - In REQ before the AR handshake, or in REQ on the handshake cycle: set drop=1; the outstanding read completes and is discarded.
  - In RESP with no rvalid: set drop=1.
  - In RESP on the same cycle as rvalid: data discarded, go to REQ, drop stays 0.
  - In OUT without fetch_ready: fetch_valid->0, fetch_inst->INST_NOP, go to REQ.
  - In OUT on the same cycle as fetch_ready: the instruction counts as transferred; pc=redirect_pc (not pc+4), go to REQ.
  - A second redirect while drop=1 only updates pc; drop stays 1 and only one response is discarded.
- At most one read is outstanding. Best-case throughput: 1 instruction per 3 cycles with a zero-wait memory.
- rst asserted mid-transaction returns everything to reset values immediately. A memory response arriving after reset must not be accepted (ifu_rready=0).
- State encoding: REQ / RESP / OUT in 2 bits. Unreachable code 3 recovers to REQ.

Optional Feature:
- Macro: IFU_ACCESS_FAULT_EN.
- When defined:
  - Adds input ifu_rresp[1:0] and output fetch_fault (1 bit, reset 0, held with fetch_valid).
  - A non-zero rresp on an accepted response presents fetch_inst=INST_NOP with fetch_fault=1.
  - fetch_fault clears on the OUT handshake or on redirect.
- When undefined: neither port exists and every response is treated as OKAY.

Test Plan:
- Reset release with a zero-wait memory (arready=rvalid=1) and fetch_ready=1 -> araddr sequence 0x80000000, 0x80000004, 0x80000008; fetch_valid pulses every 3 cycles with matching pc/inst.
- Backpressure: fetch_ready=0 for 5 cycles in OUT -> fetch_valid/pc/inst stable for all 5 cycles, no new AR issued; release -> next araddr = pc+4.
- arready held 0 for 4 cycles with a redirect to 0x80000103 in cycle 2 -> araddr stays 0x80000000 until accepted; that response is discarded; next araddr 0x80000100; fetch_valid never asserts for 0x80000000.
- Redirect in the same cycle as the fetch_ready handshake at pc 0x80000010 -> that instruction is delivered once; next araddr is the redirect target, not 0x80000014.
- rst pulse while in RESP, with rvalid arriving 1 cycle after release -> outputs at reset values, rready=0 so the response is not taken; fetch restarts at 0x80000000.
- IFU_ACCESS_FAULT_EN build, rresp=2'b10 on the first fetch -> fetch_inst=0x00000013, fetch_fault=1; cleared after the handshake.
